// File: rtl/instr_prefetch_buffer_if.sv
// ============================================================================
// Module : instr_prefetch_buffer_if
// Brief  : Memory-side and IF-stage-side signals of the instruction prefetch buffer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_prefetch_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_ready;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_instr;

  // The prefetch buffer itself.
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, if_ready
  );

  // Memory plus core environment.
  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, if_ready
  );
endinterface

`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
// ============================================================================
// Module : instr_prefetch_buffer
// Brief  : Sequential instruction prefetch FIFO with redirect flush, one fetch
//          in flight. Optional same-cycle bypass when built with PF_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_prefetch_buffer #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_prefetch_buffer_if.master   bus
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d    [DEPTH];
  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [DATA_W-1:0] instr_mem_d [DEPTH];

  logic fifo_empty;
  logic resp_keep;
  logic bypass;
  logic bypass_take;
  logic push;
  logic pop;
  logic req;

  always_comb begin
    fifo_empty = (count_q == '0);
    resp_keep  = (state_q == ST_WAIT) && bus.imem_rvalid && !bus.redirect;
`ifdef PF_BYPASS_EN
    bypass      = resp_keep && fifo_empty;
    bypass_take = bypass && bus.if_ready;
`else
    bypass      = 1'b0;
    bypass_take = 1'b0;
`endif
    push = resp_keep && !bypass_take;
    pop  = !fifo_empty && bus.if_ready && !bus.redirect;
    // A request reserves a slot, so count plus in-flight never exceeds DEPTH.
    req  = rst && (state_q == ST_RUN) && !bus.redirect && (count_q < DEPTH_CNT);
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    case (state_q)
      ST_RUN: begin
        if (req) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.redirect) begin
          state_d = bus.imem_rvalid ? ST_RUN : ST_DISCARD;
        end else if (bus.imem_rvalid) begin
          state_d    = ST_RUN;
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
      end
      ST_DISCARD: begin
        if (bus.imem_rvalid) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (bus.redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = bus.imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  always_comb begin
    bus.imem_req  = req;
    bus.imem_addr = fetch_pc_q;
    bus.if_valid  = !fifo_empty || bypass;
    if (!fifo_empty) begin
      bus.if_pc    = pc_mem_q[rd_ptr_q];
      bus.if_instr = instr_mem_q[rd_ptr_q];
    end else if (bypass) begin
      bus.if_pc    = fetch_pc_q;
      bus.if_instr = bus.imem_rdata;
    end else begin
      bus.if_pc    = '0;
      bus.if_instr = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
// ============================================================================
// Module : tb_instr_prefetch_buffer
// Brief  : Directed bench for instr_prefetch_buffer with a fixed-latency memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_prefetch_buffer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instr_prefetch_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_prefetch_buffer #(
    .DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          lat;
  logic        follow;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] req_q [$];
  logic [63:0] pop_q [$];
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // One clock cycle: drive inputs at the falling edge, sample outputs 1ns later.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy, input logic rstn);
    logic rv;
    rv = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) rv = 1'b1;
    end
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? imem_word(pend_addr) : 32'h0;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.if_ready    = follow ? rv : rdy;
    rst             = rstn;
    #1;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.if_valid;
    s_pc    = bus.if_pc;
    s_instr = bus.if_instr;
    if (s_req) begin
      req_q.push_back(s_addr);
      pend_addr = s_addr;
      pend_cnt  = lat;
    end
    if (s_valid && bus.if_ready && !redir && rstn) pop_q.push_back({s_pc, s_instr});
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    lat      = l;
    follow   = 1'b0;
    pend_cnt = 0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    req_q.delete();
    pop_q.delete();
  endtask

  task automatic test_reset();
    do_reset(1);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", s_valid); end
    checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want 0", s_pc); end
    checks++; if (s_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h want 0", s_instr); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %b want 0", s_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr [3];
    exp_addr = '{32'h0, 32'h4, 32'h8};
    do_reset(1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      errors++; $display("FAIL seq_first_req: got req=%b addr=%h want req=1 addr=0", s_req, s_addr);
    end
    for (int i = 0; i < 13; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_q.size() <= i) begin
        errors++; $display("FAIL seq_req_%0d: got none want addr %h", i, exp_addr[i]);
      end else if (req_q[i] !== exp_addr[i]) begin
        errors++; $display("FAIL seq_req_%0d: got %h want %h", i, req_q[i], exp_addr[i]);
      end
      checks++;
      if (pop_q.size() <= i) begin
        errors++; $display("FAIL seq_pop_%0d: got none want pc %h", i, exp_addr[i]);
      end else if (pop_q[i] !== {exp_addr[i], imem_word(exp_addr[i])}) begin
        errors++; $display("FAIL seq_pop_%0d: got %h want %h", i, pop_q[i], {exp_addr[i], imem_word(exp_addr[i])});
      end
    end
  endtask

  task automatic test_latency();
    do_reset(1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
`ifdef PF_BYPASS_EN
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== imem_word(32'h0)) begin
      errors++; $display("FAIL lat_bypass_same: got v=%b pc=%h i=%h want v=1 pc=0 i=%h", s_valid, s_pc, s_instr, imem_word(32'h0));
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (s_valid !== 1'b0) begin
      errors++; $display("FAIL lat_bypass_consumed: got v=%b want 0", s_valid);
    end
`else
    checks++; if (s_valid !== 1'b0) begin
      errors++; $display("FAIL lat_same_cycle: got v=%b want 0", s_valid);
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== imem_word(32'h0)) begin
      errors++; $display("FAIL lat_next_cycle: got v=%b pc=%h i=%h want v=1 pc=0 i=%h", s_valid, s_pc, s_instr, imem_word(32'h0));
    end
`endif
  endtask

  task automatic test_full();
    logic [31:0] exp_addr [4];
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset(2);
    for (int i = 0; i < 30; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (req_q.size() != 4) begin errors++; $display("FAIL full_req_count: got %0d want 4", req_q.size()); end
    checks++; if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h0) begin
      errors++; $display("FAIL full_hold: got req=%b v=%b pc=%h want req=0 v=1 pc=0", s_req, s_valid, s_pc);
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_req: got %b want 0", s_req); end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h10) begin
      errors++; $display("FAIL full_resume: got req=%b addr=%h want req=1 addr=10", s_req, s_addr);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pop_q.size() <= i) begin
        errors++; $display("FAIL full_drain_%0d: got none want pc %h", i, exp_addr[i]);
      end else if (pop_q[i] !== {exp_addr[i], imem_word(exp_addr[i])}) begin
        errors++; $display("FAIL full_drain_%0d: got %h want %h", i, pop_q[i], {exp_addr[i], imem_word(exp_addr[i])});
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset(3);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h103, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (req_q.size() != 1) begin errors++; $display("FAIL redir_no_req_in_discard: got %0d reqs want 1", req_q.size()); end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin
      errors++; $display("FAIL redir_target_req: got req=%b addr=%h want req=1 addr=100", s_req, s_addr);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== imem_word(32'h100)) begin
      errors++; $display("FAIL redir_head: got v=%b pc=%h i=%h want v=1 pc=100 i=%h", s_valid, s_pc, s_instr, imem_word(32'h100));
    end
  endtask

  task automatic test_redirect_rvalid();
    logic old_seen;
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h200, 1'b0, 1'b1);
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
      errors++; $display("FAIL redrv_pre_head: got v=%b pc=%h want v=1 pc=0", s_valid, s_pc);
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL redrv_flushed: got v=%b want 0", s_valid); end
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin
      errors++; $display("FAIL redrv_target_req: got req=%b addr=%h want req=1 addr=200", s_req, s_addr);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    old_seen = 1'b0;
    foreach (pop_q[i]) if (pop_q[i][63:32] < 32'h200) old_seen = 1'b1;
    checks++; if (old_seen !== 1'b0) begin errors++; $display("FAIL redrv_old_pc: got old entry popped want none"); end
    checks++;
    if (pop_q.size() == 0) begin
      errors++; $display("FAIL redrv_first_pop: got none want pc 200");
    end else if (pop_q[0] !== {32'h200, imem_word(32'h200)}) begin
      errors++; $display("FAIL redrv_first_pop: got %h want %h", pop_q[0], {32'h200, imem_word(32'h200)});
    end
  endtask

  task automatic test_back_to_back();
    logic        all_valid;
    logic        order_ok;
    logic [31:0] bad_got;
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    follow    = 1'b1;
    all_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      if (s_valid !== 1'b1) all_valid = 1'b0;
    end
    follow = 1'b0;
    checks++; if (all_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_held: got a cycle with v=0 want v=1 always"); end
    order_ok = (pop_q.size() >= 8);
    bad_got  = 32'h0;
    for (int i = 0; i < 8 && i < pop_q.size(); i++) begin
      if (order_ok && pop_q[i] !== {32'(i * 4), imem_word(32'(i * 4))}) begin
        order_ok = 1'b0;
        bad_got  = pop_q[i][63:32];
      end
    end
    checks++; if (order_ok !== 1'b1) begin
      errors++; $display("FAIL b2b_order: got pops=%0d bad_pc=%h want 8+ pops pc 0..1c in order", pop_q.size(), bad_got);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (s_pc !== 32'(pop_q.size() * 4)) begin
      errors++; $display("FAIL b2b_head_after: got %h want %h", s_pc, 32'(pop_q.size() * 4));
    end
  endtask

  task automatic test_reset_mid();
    do_reset(4);
    step(1'b1, 32'h40, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got req=%b v=%b want 0 0", s_req, s_valid);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      errors++; $display("FAIL rstmid_first_req: got req=%b addr=%h want req=1 addr=0", s_req, s_addr);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== imem_word(32'h0)) begin
      errors++; $display("FAIL rstmid_head: got v=%b pc=%h i=%h want v=1 pc=0 i=%h", s_valid, s_pc, s_instr, imem_word(32'h0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b0;
    lat             = 1;
    follow          = 1'b0;
    pend_cnt        = 0;
    pend_addr       = 32'h0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.if_ready    = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_sequential();
    test_full();
    test_redirect_wait();
    test_redirect_rvalid();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
